winograd_stream_acc: RTL and testbench

- Streaming, parametrised successor to the single-shot Winograd tile multiplier.
- Accepts one vector beat per cycle over a valid/ready handshake. Each beat carries 2*N_PAIRS operand pairs.
- Computes each beat's exact dot product in Winograd pairwise form and accumulates cfg_len beats into one result.
- Returns the result on a valid/ready output port. Runtime unsigned/signed mode. Sits between the operand buffers and the layer write-back path.

---
 rtl/winograd_pkg.sv | 22 ++
 rtl/winograd_dot.sv | 51 +++++
 rtl/winograd_stream_acc.sv | 224 ++++++++++++++++++++++
 tb/tb_winograd_stream_acc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// winograd_pkg
//   Shared definitions for the streaming Winograd accumulator.
//   dot_size() : width of one beat's exact dot product. It holds
//                2*n_pairs products of in0 x in1 bits, plus one sign bit.
//   out_size() : dot width plus the accumulation guard bits.
//   acc_state_e: states of the group accumulator.
package winograd_pkg;

    function automatic int dot_size(input int in0, input int in1, input int n_pairs);
        return in0 + in1 + $clog2(2 * n_pairs) + 1;
    endfunction

    function automatic int out_size(input int dot, input int extra);
        return dot + extra;
    endfunction

    typedef enum logic {
        ST_FIRST,
        ST_ACC
    } acc_state_e;

endpackage

// File: rtl/winograd_dot.sv
// winograd_dot
//   Combinational, sign-aware dot product of 2*N_PAIRS lane pairs.
//   It uses the Winograd pairwise form:
//     sum_j (a[2j]+b[2j+1])*(a[2j+1]+b[2j]) - sum_j a[2j]*a[2j+1] - sum_j b[2j]*b[2j+1]
//   Ports:
//     a_i      in   2*N_PAIRS lanes of IN_SIZE_0 bits (operand A)
//     b_i      in   2*N_PAIRS lanes of IN_SIZE_1 bits (operand B)
//     signed_i in   1 = lanes are two's complement, 0 = unsigned
//     dot_o    out  exact dot product, DOT_SIZE bits, two's complement
module winograd_dot
    import winograd_pkg::*;
#(
    parameter  int IN_SIZE_0 = 4,
    parameter  int IN_SIZE_1 = 8,
    parameter  int N_PAIRS   = 4,
    localparam int LANES     = 2 * N_PAIRS,
    localparam int DOT_SIZE  = dot_size(IN_SIZE_0, IN_SIZE_1, N_PAIRS)
) (
    input  logic [0:LANES-1][IN_SIZE_0-1:0] a_i,
    input  logic [0:LANES-1][IN_SIZE_1-1:0] b_i,
    input  logic                            signed_i,
    output logic [DOT_SIZE-1:0]             dot_o
);

    logic [DOT_SIZE-1:0] a_ext [LANES];
    logic [DOT_SIZE-1:0] b_ext [LANES];
    logic [DOT_SIZE-1:0] cross_sum;
    logic [DOT_SIZE-1:0] a_sum;
    logic [DOT_SIZE-1:0] b_sum;

    // The exact dot product always fits in DOT_SIZE bits. So every partial term
    // can be computed modulo 2^DOT_SIZE, and the cancelling cross terms still
    // reduce to the true result.
    always_comb begin
        // NOTE: every variable gets a value before any condition or loop, so no latch is inferred.
        cross_sum = '0;
        a_sum     = '0;
        b_sum     = '0;
        for (int i = 0; i < LANES; i++) begin
            a_ext[i] = signed_i ? DOT_SIZE'($signed(a_i[i])) : DOT_SIZE'(a_i[i]);
            b_ext[i] = signed_i ? DOT_SIZE'($signed(b_i[i])) : DOT_SIZE'(b_i[i]);
        end
        for (int j = 0; j < N_PAIRS; j++) begin
            cross_sum = cross_sum + (a_ext[2*j] + b_ext[2*j+1]) * (a_ext[2*j+1] + b_ext[2*j]);
            a_sum     = a_sum + a_ext[2*j] * a_ext[2*j+1];
            b_sum     = b_sum + b_ext[2*j] * b_ext[2*j+1];
        end
        dot_o = cross_sum - a_sum - b_sum;
    end

endmodule

// File: rtl/winograd_stream_acc.sv
// winograd_stream_acc
//   Streaming Winograd dot-product accumulator. Each accepted beat of
//   2*N_PAIRS operand pairs is reduced to its exact dot product. cfg_len beats
//   are summed into one result, which wraps modulo 2^OUT_SIZE.
//   Pipeline: S1 input register -> winograd_dot -> S2 dot register ->
//             S3 accumulator FSM and output register.
//   Ports:
//     clk_i, rst_i     clock; synchronous active-high reset
//     cfg_len_i        beats per result (0 acts as 1), latched per group
//     cfg_signed_i     operand signedness, latched per group
//     in_valid_i/in_ready_o   beat handshake
//     in_0_i, in_1_i   operand A / operand B lanes
//     out_valid_o/out_ready_i result handshake
//     out_o            accumulated result, OUT_SIZE bits
//     busy_o           a group is partially accumulated or in flight
module winograd_stream_acc
    import winograd_pkg::*;
#(
    parameter  int IN_SIZE_0 = 4,
    parameter  int IN_SIZE_1 = 8,
    parameter  int N_PAIRS   = 4,
    parameter  int ACC_EXTRA = 8,
    parameter  int CNT_W     = 8,
    localparam int LANES     = 2 * N_PAIRS,
    localparam int DOT_SIZE  = dot_size(IN_SIZE_0, IN_SIZE_1, N_PAIRS),
    localparam int OUT_SIZE  = out_size(DOT_SIZE, ACC_EXTRA)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [CNT_W-1:0]                cfg_len_i,
    input  logic                            cfg_signed_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [0:LANES-1][IN_SIZE_0-1:0] in_0_i,
    input  logic [0:LANES-1][IN_SIZE_1-1:0] in_1_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [OUT_SIZE-1:0]             out_o,
    output logic                            busy_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef logic [0:LANES-1][IN_SIZE_0-1:0] lanes_a_t;
    typedef logic [0:LANES-1][IN_SIZE_1-1:0] lanes_b_t;

    logic stall;

    // Input-side group tracker. It latches the configuration on the first beat of a group.
    logic [CNT_W-1:0] grp_cnt_q, grp_cnt_d;
    logic [CNT_W-1:0] grp_len_q, grp_len_d;
    logic             grp_signed_q, grp_signed_d;
    logic [CNT_W-1:0] eff_len;
    logic [CNT_W-1:0] beat_len;
    logic             beat_signed;
    logic             grp_first;

    // S1
    logic             s1_valid_q, s1_valid_d;
    lanes_a_t         s1_a_q, s1_a_d;
    lanes_b_t         s1_b_q, s1_b_d;
    logic             s1_signed_q, s1_signed_d;
    logic [CNT_W-1:0] s1_len_q, s1_len_d;

    logic [DOT_SIZE-1:0] dot;

    // S2
    logic                s2_valid_q, s2_valid_d;
    logic [DOT_SIZE-1:0] s2_dot_q, s2_dot_d;
    logic [CNT_W-1:0]    s2_len_q, s2_len_d;

    // S3
    acc_state_e          state_q, state_d;
    logic [OUT_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OUT_SIZE-1:0] out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_SIZE-1:0] dot_ext;
    logic [OUT_SIZE-1:0] sum;

    // The whole pipeline freezes only while a finished result waits for the consumer.
    always_comb begin
        stall      = out_valid_q && !out_ready_i;
        in_ready_o = !stall;
    end

    // Group tracker: each beat carries the length and signedness of its own group.
    always_comb begin
        eff_len      = (cfg_len_i == '0) ? CNT_ONE : cfg_len_i;
        grp_first    = (grp_cnt_q == '0);
        beat_len     = grp_first ? eff_len : grp_len_q;
        beat_signed  = grp_first ? cfg_signed_i : grp_signed_q;
        grp_cnt_d    = grp_cnt_q;
        grp_len_d    = grp_len_q;
        grp_signed_d = grp_signed_q;
        if (in_valid_i && !stall) begin
            grp_len_d    = beat_len;
            grp_signed_d = beat_signed;
            grp_cnt_d    = (grp_cnt_q == beat_len - CNT_ONE) ? '0 : grp_cnt_q + CNT_ONE;
        end
    end

    // S1 and S2 advance together. They hold while the output is stalled.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_signed_d = s1_signed_q;
        s1_len_d    = s1_len_q;
        s2_valid_d  = s2_valid_q;
        s2_dot_d    = s2_dot_q;
        s2_len_d    = s2_len_q;
        if (!stall) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_a_d      = in_0_i;
                s1_b_d      = in_1_i;
                s1_signed_d = beat_signed;
                s1_len_d    = beat_len;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_dot_d = dot;
                s2_len_d = s1_len_q;
            end
        end
    end

    winograd_dot #(
        .IN_SIZE_0 (IN_SIZE_0),
        .IN_SIZE_1 (IN_SIZE_1),
        .N_PAIRS   (N_PAIRS)
    ) u_dot (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .signed_i (s1_signed_q),
        .dot_o    (dot)
    );

    // Accumulator FSM and output register.
    always_comb begin
        // An unsigned dot never reaches bit DOT_SIZE-1. So sign extension is
        // correct in both modes.
        dot_ext     = OUT_SIZE'($signed(s2_dot_q));
        sum         = acc_q + dot_ext;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        // A completed handshake frees the register. A new result below may refill it in the same cycle.
        out_valid_d = out_valid_q && !out_ready_i;
        if (s2_valid_q && !stall) begin
            case (state_q)
                ST_FIRST: begin
                    if (s2_len_q == CNT_ONE) begin
                        out_d       = dot_ext;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d   = dot_ext;
                        cnt_d   = CNT_ONE;
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (cnt_q == s2_len_q - CNT_ONE) begin
                        out_d       = sum;
                        out_valid_d = 1'b1;
                        state_d     = ST_FIRST;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            grp_cnt_q    <= '0;
            grp_len_q    <= CNT_ONE;
            grp_signed_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_signed_q  <= 1'b0;
            s1_len_q     <= CNT_ONE;
            s2_valid_q   <= 1'b0;
            s2_dot_q     <= '0;
            s2_len_q     <= CNT_ONE;
            state_q      <= ST_FIRST;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            grp_cnt_q    <= grp_cnt_d;
            grp_len_q    <= grp_len_d;
            grp_signed_q <= grp_signed_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_signed_q  <= s1_signed_d;
            s1_len_q     <= s1_len_d;
            s2_valid_q   <= s2_valid_d;
            s2_dot_q     <= s2_dot_d;
            s2_len_q     <= s2_len_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        out_o       = out_q;
        out_valid_o = out_valid_q;
        busy_o      = s1_valid_q || s2_valid_q || (state_q == ST_ACC) || out_valid_q;
    end

endmodule

// File: tb/tb_winograd_stream_acc.sv
// tb_winograd_stream_acc
//   Directed bench for winograd_stream_acc with default parameters:
//   8 lanes of 4-bit x 8-bit operands and a 24-bit result.
module tb_winograd_stream_acc;
    import winograd_pkg::*;

    localparam int IN_SIZE_0 = 4;
    localparam int IN_SIZE_1 = 8;
    localparam int N_PAIRS   = 4;
    localparam int ACC_EXTRA = 8;
    localparam int CNT_W     = 8;
    localparam int LANES     = 2 * N_PAIRS;
    localparam int OUT_SIZE  = out_size(dot_size(IN_SIZE_0, IN_SIZE_1, N_PAIRS), ACC_EXTRA);

    logic                            clk_i;
    logic                            rst_i;
    logic [CNT_W-1:0]                cfg_len_i;
    logic                            cfg_signed_i;
    logic                            in_valid_i;
    logic                            in_ready_o;
    logic [0:LANES-1][IN_SIZE_0-1:0] in_0_i;
    logic [0:LANES-1][IN_SIZE_1-1:0] in_1_i;
    logic                            out_valid_o;
    logic                            out_ready_i;
    logic [OUT_SIZE-1:0]             out_o;
    logic                            busy_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    logic [OUT_SIZE-1:0] res_q [$];
    int                  res_cyc [$];

    winograd_stream_acc #(
        .IN_SIZE_0 (IN_SIZE_0),
        .IN_SIZE_1 (IN_SIZE_1),
        .N_PAIRS   (N_PAIRS),
        .ACC_EXTRA (ACC_EXTRA),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_len_i    (cfg_len_i),
        .cfg_signed_i (cfg_signed_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_0_i       (in_0_i),
        .in_1_i       (in_1_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_o        (out_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Each negedge that shows valid && ready is exactly one handshake at the next edge.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            res_q.push_back(out_o);
            res_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    // Call this just after a posedge. It returns just after the edge that accepts the beat.
    task automatic put(input logic [IN_SIZE_0-1:0] a, input logic [IN_SIZE_1-1:0] b,
                       input logic [CNT_W-1:0] len, input logic sgn);
        int n;
        in_0_i       = {LANES{a}};
        in_1_i       = {LANES{b}};
        cfg_len_i    = len;
        cfg_signed_i = sgn;
        in_valid_i   = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (in_ready_o !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        check("beat_accepted", 32'(in_ready_o), 32'd1);
        last_acc = cyc;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (res_q.size() < n && k < 60) begin
            k++;
            @(negedge clk_i);
        end
        repeat (5) @(negedge clk_i);
    endtask

    task automatic clear_results();
        res_q.delete();
        res_cyc.delete();
    endtask

    initial begin
        // Reset while a beat is offered. That beat must never produce a result.
        rst_i        = 1'b1;
        in_valid_i   = 1'b1;
        in_0_i       = {LANES{4'd5}};
        in_1_i       = {LANES{8'd9}};
        cfg_len_i    = 8'd1;
        cfg_signed_i = 1'b0;
        out_ready_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out",       32'(out_o),       32'd0);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_in_ready",  32'(in_ready_o),  32'd1);
        repeat (6) @(negedge clk_i);
        check("rst_no_result", res_q.size(), 32'd0);

        // Unsigned, len=1: 8 * 3 * 5 = 120, three cycles after acceptance.
        sync();
        put(4'd3, 8'd5, 8'd1, 1'b0);
        wait_results(1);
        check("u1_count",   res_q.size(), 32'd1);
        check("u1_value",   32'(res_q[0]), 32'd120);
        check("u1_latency", res_cyc[0] - last_acc, 32'd3);
        clear_results();

        // Three back-to-back beats give three results on consecutive cycles.
        sync();
        put(4'd1, 8'd1, 8'd1, 1'b0);
        put(4'd2, 8'd1, 8'd1, 1'b0);
        put(4'd3, 8'd1, 8'd1, 1'b0);
        wait_results(3);
        check("b2b_count", res_q.size(), 32'd3);
        check("b2b_v0",    32'(res_q[0]), 32'd8);
        check("b2b_v1",    32'(res_q[1]), 32'd16);
        check("b2b_v2",    32'(res_q[2]), 32'd24);
        check("b2b_gap01", res_cyc[1] - res_cyc[0], 32'd1);
        check("b2b_gap12", res_cyc[2] - res_cyc[1], 32'd1);
        clear_results();

        // Unsigned, len=4: 4 * 8 * 15 * 255 = 122400, one result only.
        sync();
        repeat (4) put(4'd15, 8'd255, 8'd4, 1'b0);
        wait_results(1);
        check("u4_count",   res_q.size(), 32'd1);
        check("u4_value",   32'(res_q[0]), 32'd122400);
        check("u4_latency", res_cyc[0] - last_acc, 32'd3);
        clear_results();

        // Signed, len=2: 2 * 8 * (-8 * 127) = -16256 -> 24'hFFC080.
        sync();
        repeat (2) put(4'h8, 8'h7F, 8'd2, 1'b1);
        wait_results(1);
        check("s2_count", res_q.size(), 32'd1);
        check("s2_value", 32'(res_q[0]), 32'h00FF_C080);
        clear_results();

        // Backpressure: three beats are accepted, then the first result stalls the pipe.
        sync();
        out_ready_i = 1'b0;
        put(4'd1, 8'd1, 8'd1, 1'b0);
        put(4'd2, 8'd1, 8'd1, 1'b0);
        put(4'd3, 8'd1, 8'd1, 1'b0);
        in_0_i     = {LANES{4'd4}};
        in_1_i     = {LANES{8'd1}};
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_hold_valid", 32'(out_valid_o), 32'd1);
            check("bp_hold_value", 32'(out_o),       32'd8);
            check("bp_in_ready",   32'(in_ready_o),  32'd0);
        end
        check("bp_none_yet", res_q.size(), 32'd0);
        sync();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_ready", 32'(in_ready_o), 32'd1);
        sync();
        in_valid_i = 1'b0;
        wait_results(4);
        check("bp_count", res_q.size(), 32'd4);
        check("bp_v0",    32'(res_q[0]), 32'd8);
        check("bp_v1",    32'(res_q[1]), 32'd16);
        check("bp_v2",    32'(res_q[2]), 32'd24);
        check("bp_v3",    32'(res_q[3]), 32'd32);
        clear_results();

        // A reset mid-group discards the partial group.
        sync();
        repeat (2) put(4'd1, 8'd1, 8'd4, 1'b0);
        repeat (3) @(negedge clk_i);
        check("mid_busy", 32'(busy_o), 32'd1);
        sync();
        rst_i = 1'b1;
        sync();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_busy",  32'(busy_o),      32'd0);
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        sync();
        put(4'd1, 8'd1, 8'd1, 1'b0);
        wait_results(1);
        check("mid_count", res_q.size(), 32'd1);
        check("mid_value", 32'(res_q[0]), 32'd8);
        clear_results();

        // Changing cfg_len mid-group has no effect until the next group starts.
        sync();
        put(4'd1, 8'd1, 8'd4, 1'b0);
        repeat (3) put(4'd1, 8'd1, 8'd1, 1'b0);
        put(4'd2, 8'd1, 8'd1, 1'b0);
        wait_results(2);
        check("cfg_count", res_q.size(), 32'd2);
        check("cfg_group", 32'(res_q[0]), 32'd32);
        check("cfg_next",  32'(res_q[1]), 32'd16);
        clear_results();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
